// File: rtl/approx_prefix_adder_pipe.sv
// ============================================================================
// Module   : approx_prefix_adder_pipe
// Purpose  : Pipelined Kogge-Stone adder with per-beat exact / lower-part-OR
//            approximate mode and valid/ready handshakes on both sides.
// Options  : APPROX_ADDER_ERR_CNT_EN adds an exact shadow sum and an error
//            counter (err_clr_i, err_cnt_o).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module approx_prefix_adder_pipe #(
    parameter int WIDTH       = 32,
    parameter int APPROX_BITS = 8,
    parameter int STAGES      = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    input  logic             approx_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o
`ifdef APPROX_ADDER_ERR_CNT_EN
    ,
    input  logic             err_clr_i,
    output logic [31:0]      err_cnt_o
`endif
);

    localparam int LEVELS  = $clog2(WIDTH);
    localparam int LV_BASE = LEVELS / STAGES;
    localparam int LV_REM  = LEVELS % STAGES;

    // Inter-stage links: slot k is the data entering register stage k.
    logic [STAGES-1:0][WIDTH-1:0] lk_p;
    logic [STAGES-1:0][WIDTH-1:0] lk_g;
    logic [STAGES-1:0][WIDTH-1:0] lk_h;
    logic [STAGES-1:0]            lk_c0;

    logic [STAGES-1:0] vld;
    logic [STAGES-1:0] vin;
    logic [STAGES:0]   rdy;

    logic [WIDTH-1:0]  sum_q;
    logic              cout_q;

    // Bit-level P/G. In approximate mode the low bits leave the prefix tree
    // except bit k-1, whose generate becomes the carry into bit k.
    logic [WIDTH-1:0] pre_p;
    logic [WIDTH-1:0] pre_g;
    logic [WIDTH-1:0] pre_h;
    logic             pre_c0;

    always_comb begin
        pre_p  = a_i ^ b_i;
        pre_g  = a_i & b_i;
        pre_h  = a_i ^ b_i;
        pre_c0 = cin_i;
        if ((APPROX_BITS > 0) && approx_i) begin
            pre_c0 = 1'b0;
            for (int i = 0; i < WIDTH; i++) begin
                if (i < APPROX_BITS) begin
                    pre_p[i] = 1'b0;
                    pre_g[i] = 1'b0;
                    pre_h[i] = a_i[i] | b_i[i];
                end
                if (i == APPROX_BITS - 1) begin
                    pre_g[i] = a_i[i] & b_i[i];
                end
            end
        end
        // Folding carry-in into bit 0 keeps the tree at log2(WIDTH) levels.
        pre_g[0] = pre_g[0] | (pre_p[0] & pre_c0);
    end

    assign lk_p[0]  = pre_p;
    assign lk_g[0]  = pre_g;
    assign lk_h[0]  = pre_h;
    assign lk_c0[0] = pre_c0;

    always_comb begin
        rdy[STAGES] = out_ready_i;
        for (int k = STAGES - 1; k >= 0; k--) begin
            rdy[k] = ~vld[k] | rdy[k+1];
        end
    end

    always_comb begin
        vin[0] = in_valid_i;
        for (int k = 1; k < STAGES; k++) begin
            vin[k] = vld[k-1];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld <= '0;
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (rdy[k]) begin
                    vld[k] <= vin[k];
                end
            end
        end
    end

`ifdef APPROX_ADDER_ERR_CNT_EN
    logic [STAGES-1:0][WIDTH:0] lk_x;
    logic [WIDTH:0]             exact_q;
    logic [31:0]                err_cnt;

    assign lk_x[0] = {1'b0, a_i} + {1'b0, b_i} + {{WIDTH{1'b0}}, cin_i};
`endif

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int FIRST = k * LV_BASE + ((k < LV_REM) ? k : LV_REM);
        localparam int CNT   = LV_BASE + ((k < LV_REM) ? 1 : 0);

        logic [WIDTH-1:0] p_n;
        logic [WIDTH-1:0] g_n;
        logic [WIDTH-1:0] p_t;
        logic [WIDTH-1:0] g_t;
        logic             load;

        assign load = rdy[k] & vin[k];

        // Prefix levels FIRST .. FIRST+CNT-1; earlier stages take the extra level.
        always_comb begin
            p_n = lk_p[k];
            g_n = lk_g[k];
            p_t = '0;
            g_t = '0;
            for (int j = 0; j < LEVELS; j++) begin
                if ((j >= FIRST) && (j < FIRST + CNT)) begin
                    p_t = p_n;
                    g_t = g_n;
                    for (int i = 0; i < WIDTH; i++) begin
                        if (i >= (1 << j)) begin
                            g_n[i] = g_t[i] | (p_t[i] & g_t[i - (1 << j)]);
                            p_n[i] = p_t[i] & p_t[i - (1 << j)];
                        end
                    end
                end
            end
        end

        if (k < STAGES - 1) begin : g_mid
            logic [WIDTH-1:0] p_q;
            logic [WIDTH-1:0] g_q;
            logic [WIDTH-1:0] h_q;
            logic             c0_q;

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    p_q  <= '0;
                    g_q  <= '0;
                    h_q  <= '0;
                    c0_q <= 1'b0;
                end else if (load) begin
                    p_q  <= p_n;
                    g_q  <= g_n;
                    h_q  <= lk_h[k];
                    c0_q <= lk_c0[k];
                end
            end

            assign lk_p[k+1]  = p_q;
            assign lk_g[k+1]  = g_q;
            assign lk_h[k+1]  = h_q;
            assign lk_c0[k+1] = c0_q;

`ifdef APPROX_ADDER_ERR_CNT_EN
            logic [WIDTH:0] x_q;

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    x_q <= '0;
                end else if (load) begin
                    x_q <= lk_x[k];
                end
            end

            assign lk_x[k+1] = x_q;
`endif
        end else begin : g_last
            // g_n[i] is now the carry out of bit i, so the carries shift up by one.
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    sum_q  <= '0;
                    cout_q <= 1'b0;
                end else if (load) begin
                    sum_q  <= lk_h[k] ^ {g_n[WIDTH-2:0], lk_c0[k]};
                    cout_q <= g_n[WIDTH-1];
                end
            end

`ifdef APPROX_ADDER_ERR_CNT_EN
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    exact_q <= '0;
                end else if (load) begin
                    exact_q <= lk_x[k];
                end
            end
`endif
        end
    end

`ifdef APPROX_ADDER_ERR_CNT_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_cnt <= '0;
        end else if (err_clr_i) begin
            err_cnt <= '0;
        end else if (vld[STAGES-1] && out_ready_i &&
                     ({cout_q, sum_q} != exact_q) && (err_cnt != 32'hFFFF_FFFF)) begin
            err_cnt <= err_cnt + 32'd1;
        end
    end

    assign err_cnt_o = err_cnt;
`endif

    assign in_ready_o  = rdy[0];
    assign out_valid_o = vld[STAGES-1];
    assign sum_o       = sum_q;
    assign cout_o      = cout_q;

endmodule

`default_nettype wire

// File: tb/tb_approx_prefix_adder_pipe.sv
// ============================================================================
// Module   : tb_approx_prefix_adder_pipe
// Purpose  : Directed self-checking bench for approx_prefix_adder_pipe
//            (WIDTH=32, APPROX_BITS=8, STAGES=2).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_approx_prefix_adder_pipe;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         approx;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
`ifdef APPROX_ADDER_ERR_CNT_EN
    logic         err_clr;
    logic [31:0]  err_cnt;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    approx_prefix_adder_pipe #(
        .WIDTH       (W),
        .APPROX_BITS (8),
        .STAGES      (2)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .a_i         (a),
        .b_i         (b),
        .cin_i       (cin),
        .approx_i    (approx),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .sum_o       (sum),
        .cout_o      (cout)
`ifdef APPROX_ADDER_ERR_CNT_EN
        ,
        .err_clr_i   (err_clr),
        .err_cnt_o   (err_cnt)
`endif
    );

    // Reference: exact add, or low-byte OR with carry a[7]&b[7] into bit 8.
    function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic ci, input logic ap);
        logic [W-8:0] hi;
        if (!ap) begin
            return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
        end
        hi = {1'b0, x[W-1:8]} + {1'b0, y[W-1:8]} + {{(W-8){1'b0}}, x[7] & y[7]};
        return {hi, x[7:0] | y[7:0]};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; approx = 1'b0;
        out_ready = 1'b1;
`ifdef APPROX_ADDER_ERR_CNT_EN
        err_clr = 1'b0;
`endif
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        n_cmp++; if (sum !== 32'h0) begin n_bad++; $display("FAIL reset_sum: got %h want 00000000", sum); end
        n_cmp++; if (cout !== 1'b0) begin n_bad++; $display("FAIL reset_cout: got %b want 0", cout); end
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
`ifdef APPROX_ADDER_ERR_CNT_EN
        n_cmp++; if (err_cnt !== 32'd0) begin n_bad++; $display("FAIL reset_err_cnt: got %0d want 0", err_cnt); end
`endif
    endtask

    task automatic test_exact_ripple;
        a = 32'hFFFF_FFFF; b = 32'h0000_0001; cin = 1'b0; approx = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL ripple_early_valid: got %b want 0", out_valid); end
        tick();
        n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL ripple_valid: got %b want 1", out_valid); end
        n_cmp++; if ({cout, sum} !== 33'h1_0000_0000) begin n_bad++; $display("FAIL ripple_sum: got %b_%h want 1_00000000", cout, sum); end
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL ripple_drain: got %b want 0", out_valid); end
    endtask

    task automatic test_approx_nocarry;
        a = 32'h0000_00FF; b = 32'h0000_0001; cin = 1'b0; approx = 1'b1; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL nocarry_valid: got %b want 1", out_valid); end
        n_cmp++; if ({cout, sum} !== 33'h0_0000_00FF) begin n_bad++; $display("FAIL nocarry_sum: got %b_%h want 0_000000ff", cout, sum); end
`ifdef APPROX_ADDER_ERR_CNT_EN
        n_cmp++; if (err_cnt !== 32'd0) begin n_bad++; $display("FAIL nocarry_err_before: got %0d want 0", err_cnt); end
`endif
        tick();
`ifdef APPROX_ADDER_ERR_CNT_EN
        n_cmp++; if (err_cnt !== 32'd1) begin n_bad++; $display("FAIL nocarry_err_after: got %0d want 1", err_cnt); end
`endif
    endtask

    task automatic test_approx_gen_carry;
        a = 32'h0000_0080; b = 32'h0000_0080; cin = 1'b0; approx = 1'b1; in_valid = 1'b1;
        tick();
        approx = 1'b0;
        tick();
        in_valid = 1'b0;
        n_cmp++; if (sum !== 32'h0000_0180 || out_valid !== 1'b1) begin n_bad++; $display("FAIL gencarry_approx: got v=%b %h want v=1 00000180", out_valid, sum); end
        tick();
        n_cmp++; if (sum !== 32'h0000_0100 || out_valid !== 1'b1) begin n_bad++; $display("FAIL gencarry_exact: got v=%b %h want v=1 00000100", out_valid, sum); end
`ifdef APPROX_ADDER_ERR_CNT_EN
        n_cmp++; if (err_cnt !== 32'd2) begin n_bad++; $display("FAIL gencarry_err: got %0d want 2", err_cnt); end
`endif
        tick();
`ifdef APPROX_ADDER_ERR_CNT_EN
        n_cmp++; if (err_cnt !== 32'd2) begin n_bad++; $display("FAIL gencarry_err_exact: got %0d want 2", err_cnt); end
`endif
    endtask

    task automatic test_backpressure;
        out_ready = 1'b0; approx = 1'b0; cin = 1'b0;
        a = 32'd1; b = 32'd2; in_valid = 1'b1;
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_ready_beat1: got %b want 1", in_ready); end
        tick();
        a = 32'd3; b = 32'd4;
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_ready_beat2: got %b want 1", in_ready); end
        tick();
        a = 32'd5; b = 32'd6;
        for (int c = 0; c < 3; c++) begin
            n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_ready_full: cycle %0d got %b want 0", c, in_ready); end
            n_cmp++; if (out_valid !== 1'b1 || sum !== 32'd3) begin n_bad++; $display("FAIL bp_hold: cycle %0d got v=%b %0d want v=1 3", c, out_valid, sum); end
            if (c < 2) tick();
        end
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        n_cmp++; if (out_valid !== 1'b1 || sum !== 32'd7) begin n_bad++; $display("FAIL bp_second: got v=%b %0d want v=1 7", out_valid, sum); end
        tick();
        n_cmp++; if (out_valid !== 1'b1 || sum !== 32'd11) begin n_bad++; $display("FAIL bp_third: got v=%b %0d want v=1 11", out_valid, sum); end
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL bp_empty: got %b want 0", out_valid); end
    endtask

    task automatic test_back_to_back;
        logic [W:0] exp_q [10];
        out_ready = 1'b1;
        for (int c = 0; c < 13; c++) begin
            if (c >= 2 && c < 12) begin
                n_cmp++;
                if (out_valid !== 1'b1 || {cout, sum} !== exp_q[c-2]) begin
                    n_bad++;
                    $display("FAIL b2b_beat%0d: got v=%b %b_%h want v=1 %b_%h", c - 2, out_valid, cout, sum, exp_q[c-2][W], exp_q[c-2][W-1:0]);
                end
            end else if (c == 12) begin
                n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_drain: got %b want 0", out_valid); end
            end
            if (c < 10) begin
                a        = 32'h89AB_CDEF + 32'(c) * 32'h0123_4567;
                b        = 32'hFEDC_BA98 ^ (32'(c) << 3);
                cin      = 1'b1;
                approx   = (c % 2 == 1);
                in_valid = 1'b1;
                exp_q[c] = model(a, b, cin, approx);
            end else begin
                in_valid = 1'b0;
            end
            tick();
        end
    endtask

    task automatic test_reset_mid;
        out_ready = 1'b0; approx = 1'b0; cin = 1'b0;
        a = 32'd1; b = 32'd1; in_valid = 1'b1;
        tick();
        a = 32'd2; b = 32'd2;
        tick();
        in_valid = 1'b0;
        n_cmp++; if (out_valid !== 1'b1 || sum !== 32'd2) begin n_bad++; $display("FAIL rstmid_pre: got v=%b %0d want v=1 2", out_valid, sum); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rstmid_valid: got %b want 0", out_valid); end
        n_cmp++; if (sum !== 32'h0 || cout !== 1'b0) begin n_bad++; $display("FAIL rstmid_sum: got %b_%h want 0_00000000", cout, sum); end
        tick();
        tick();
        rst_n = 1'b1;
        out_ready = 1'b1;
        tick();
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rstmid_in_ready: got %b want 1", in_ready); end
        for (int c = 0; c < 4; c++) begin
            n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rstmid_stale: cycle %0d got %b want 0", c, out_valid); end
            tick();
        end
`ifdef APPROX_ADDER_ERR_CNT_EN
        n_cmp++; if (err_cnt !== 32'd0) begin n_bad++; $display("FAIL rstmid_err_cnt: got %0d want 0", err_cnt); end
`endif
    endtask

    initial begin
        test_reset();
        test_exact_ripple();
        test_approx_nocarry();
        test_approx_gen_carry();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
